// File: rtl/crc8_pkg.sv
// Shared CRC-8 trailer types, default constants and the single-cycle CRC step.
package crc8_pkg;

  typedef enum logic [1:0] {PASS, CRC, WAIT, SEQ} state_e;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  // MSB-first, unreflected: fold the byte in, then shift out 8 bits.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_trailer_if.sv
// Byte-wide valid/ready stream bundle used on both sides of the CRC trailer stage.
interface crc8_trailer_if #(
  parameter int unsigned Width = 8
);
  logic [Width-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/crc8_accum.sv
// Running CRC-8 register with synchronous clear and per-byte enable.
module crc8_accum
  import crc8_pkg::*;
#(
  parameter logic [7:0] Poly = CRC8_POLY_DEFAULT,
  parameter logic [7:0] Init = CRC8_INIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] r_crc;
  logic [7:0] w_crc_next;

  assign w_crc_next = crc8_step(r_crc, data_i, Poly);
  assign crc_o      = r_crc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_crc <= Init;
    end else if (clear_i) begin
      r_crc <= Init;
    end else if (en_i) begin
      r_crc <= w_crc_next;
    end
  end

endmodule

// File: rtl/crc8_trailer.sv
// Pass-through byte stage that appends a CRC-8 byte after every PacketLenBytes-byte packet.
// Define CRC8_TRAILER_SEQ_EN to also append a wrapping frame sequence byte after the CRC.
module crc8_trailer
  import crc8_pkg::*;
#(
  parameter int unsigned Width          = 8,
  parameter int unsigned PacketLenBytes = 9463,
  parameter logic [7:0]  Poly           = CRC8_POLY_DEFAULT,
  parameter logic [7:0]  Init           = CRC8_INIT_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  crc8_trailer_if.slave  up_if,
  crc8_trailer_if.master dn_if,
  output logic [7:0]     crc_o
);

  localparam int unsigned     CntW    = $clog2(PacketLenBytes + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(PacketLenBytes - 1);

  state_e           r_state;
  logic [CntW-1:0]  r_count;
  logic [Width-1:0] r_data;
  logic             r_valid;
  logic [7:0]       r_crc_out;
`ifdef CRC8_TRAILER_SEQ_EN
  logic [7:0]       r_seq;
`endif

  logic       w_up_ready;
  logic       w_up_fire;
  logic       w_dn_fire;
  logic       w_slot_free;
  logic       w_crc_load;
  logic [7:0] w_crc;

  assign w_slot_free = !r_valid || dn_if.ready;
  assign w_up_ready  = (r_state == PASS) && w_slot_free;
  assign w_up_fire   = up_if.valid && w_up_ready;
  assign w_dn_fire   = r_valid && dn_if.ready;
  assign w_crc_load  = (r_state == CRC) && w_slot_free;

  assign up_if.ready = w_up_ready;
  assign dn_if.data  = r_data;
  assign dn_if.valid = r_valid;
  assign crc_o       = r_crc_out;

  // Cleared as the trailer is loaded, so the next packet starts from the seed.
  crc8_accum #(
    .Poly(Poly),
    .Init(Init)
  ) u_accum (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(w_crc_load),
    .en_i   (w_up_fire),
    .data_i (up_if.data[7:0]),
    .crc_o  (w_crc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= PASS;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_crc_out <= 8'h00;
`ifdef CRC8_TRAILER_SEQ_EN
      r_seq     <= 8'h00;
`endif
    end else begin
      case (r_state)
        PASS: begin
          if (w_up_fire) begin
            r_data  <= up_if.data;
            r_valid <= 1'b1;
            if (r_count == LastIdx) begin
              r_count <= '0;
              r_state <= CRC;
            end else begin
              r_count <= r_count + CntW'(1);
            end
          end else if (w_dn_fire) begin
            r_valid <= 1'b0;
          end
        end
        CRC: begin
          if (w_slot_free) begin
            r_data    <= Width'(w_crc);
            r_valid   <= 1'b1;
            r_crc_out <= w_crc;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (w_dn_fire) begin
`ifdef CRC8_TRAILER_SEQ_EN
            // Slot is reused immediately for the sequence byte.
            r_data  <= Width'(r_seq);
            r_state <= SEQ;
`else
            r_valid <= 1'b0;
            r_state <= PASS;
`endif
          end
        end
`ifdef CRC8_TRAILER_SEQ_EN
        SEQ: begin
          if (w_dn_fire) begin
            r_valid <= 1'b0;
            r_seq   <= r_seq + 8'd1;
            r_state <= PASS;
          end
        end
`endif
        default: r_state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_trailer.sv
// Randomized self-checking bench: two instances (9-byte and 1-byte packets) against a
// bit-serial CRC reference model and an expected-output scoreboard.
module tb_crc8_trailer;

  typedef logic [7:0] byte_q_t[$];

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  crc8_trailer_if #(.Width(8)) up9 ();
  crc8_trailer_if #(.Width(8)) dn9 ();
  crc8_trailer_if #(.Width(8)) up1 ();
  crc8_trailer_if #(.Width(8)) dn1 ();
  logic [7:0] crc9;
  logic [7:0] crc1;

  crc8_trailer #(.PacketLenBytes(9)) u_dut9 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .up_if (up9),
    .dn_if (dn9),
    .crc_o (crc9)
  );

  crc8_trailer #(.PacketLenBytes(1)) u_dut1 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .up_if (up1),
    .dn_if (dn1),
    .crc_o (crc1)
  );

  int n_err = 0;
  int n_chk = 0;
  bit bp    = 1'b0;  // random downstream backpressure
  bit gap   = 1'b0;  // random upstream idle cycles

  logic [7:0] drv9[$];
  logic [7:0] drv1[$];
  // Expected outputs: bits 7:0 value, bit 8 = CRC byte, bit 9 = last trailer byte.
  int exp9[$];
  int exp1[$];
  int seq_m[2];
  bit hold_m[2];
  logic [7:0] last_m[2];
  bit after_m[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit-serial polynomial division, MSB first.
  function automatic logic [7:0] ref_crc(input byte_q_t msg);
    logic [7:0] c;
    logic [7:0] m;
    logic fb;
    c = 8'h00;
    foreach (msg[i]) begin
      m = msg[i];
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ m[b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic push_exp(input int which, input int e);
    if (which == 0) exp9.push_back(e);
    else exp1.push_back(e);
  endtask

  task automatic send(input int which, input byte_q_t pkt, input bit full);
    logic [7:0] c;
    foreach (pkt[i]) begin
      if (which == 0) drv9.push_back(pkt[i]);
      else drv1.push_back(pkt[i]);
      push_exp(which, int'(pkt[i]));
    end
    if (full) begin
      c = ref_crc(pkt);
`ifdef CRC8_TRAILER_SEQ_EN
      push_exp(which, int'(c) | 256);
      push_exp(which, seq_m[which] | 512);
      seq_m[which] = (seq_m[which] + 1) % 256;
`else
      push_exp(which, int'(c) | 256 | 512);
`endif
    end
  endtask

  task automatic mon_step(input int which, input logic dv, input logic dr, input logic [7:0] dd,
                          input logic [7:0] crc, input logic uv, input logic ur);
    int e;
    int left;
    left = (which == 0) ? drv9.size() : drv1.size();
    if (hold_m[which]) begin
      check($sformatf("hold_valid%0d", which), dv, 1'b1);
      check($sformatf("hold_data%0d", which), dd, last_m[which]);
    end
    if (after_m[which] && !gap && left > 0) begin
      check($sformatf("b2b_accept%0d", which), uv && ur, 1'b1);
    end
    after_m[which] = 1'b0;
    if (dv && dr) begin
      if (((which == 0) ? exp9.size() : exp1.size()) == 0) begin
        check($sformatf("extra_out%0d", which), 0, 1);
      end else begin
        e = (which == 0) ? exp9.pop_front() : exp1.pop_front();
        check($sformatf("out%0d", which), dd, e[7:0]);
        if (e[8]) check($sformatf("crc_o%0d", which), crc, e[7:0]);
        after_m[which] = e[9];
      end
    end
    hold_m[which] = dv && !dr;
    last_m[which] = dd;
  endtask

  // Upstream and downstream drivers: change at posedge+1, handshake judged at negedge.
  initial begin
    bit f9;
    bit f1;
    up9.valid = 1'b0; up9.data = 8'h00; dn9.ready = 1'b1;
    up1.valid = 1'b0; up1.data = 8'h00; dn1.ready = 1'b1;
    forever begin
      @(negedge clk_i);
      f9 = up9.valid && up9.ready;
      f1 = up1.valid && up1.ready;
      @(posedge clk_i);
      #1;
      if (f9) drv9.delete(0);
      if (f1) drv1.delete(0);
      if (f9 || !up9.valid) begin
        up9.valid = (drv9.size() > 0) && (!gap || $urandom_range(0, 1) == 1);
        if (up9.valid) up9.data = drv9[0];
      end
      if (f1 || !up1.valid) begin
        up1.valid = (drv1.size() > 0) && (!gap || $urandom_range(0, 1) == 1);
        if (up1.valid) up1.data = drv1[0];
      end
      dn9.ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      dn1.ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hold_m  = '{default: 1'b0};
        after_m = '{default: 1'b0};
      end else begin
        mon_step(0, dn9.valid, dn9.ready, dn9.data, crc9, up9.valid, up9.ready);
        mon_step(1, dn1.valid, dn1.ready, dn1.data, crc1, up1.valid, up1.ready);
      end
    end
  end

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((drv9.size() + drv1.size() + exp9.size() + exp1.size()) != 0 && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
    end
    check("drain", drv9.size() + drv1.size() + exp9.size() + exp1.size(), 0);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_reset();
    check("rst_valid9", dn9.valid, 1'b0);
    check("rst_data9", dn9.data, 8'h00);
    check("rst_crc9", crc9, 8'h00);
    check("rst_ready9", up9.ready, 1'b1);
    check("rst_valid1", dn1.valid, 1'b0);
    check("rst_data1", dn1.data, 8'h00);
    check("rst_crc1", crc1, 8'h00);
    check("rst_ready1", up1.ready, 1'b1);
  endtask

  initial begin
    byte_q_t pkt;
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #10;
    check_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    seq_m = '{default: 0};

    // "123456789" with full throughput, and the two single-byte packets.
    pkt = {};
    for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
    send(0, pkt, 1'b1);
    send(1, '{8'hA5}, 1'b1);
    send(1, '{8'h5A}, 1'b1);
    wait_idle();
    check("crc9_check_value", crc9, 8'hF4);
    check("crc1_last", crc1, ref_crc('{8'h5A}));

    // Same stream under random backpressure and upstream gaps.
    bp = 1'b1; gap = 1'b1;
    send(0, pkt, 1'b1);
    wait_idle();
    check("crc9_bp", crc9, 8'hF4);

    // Back-to-back all-zero packets.
    bp = 1'b0; gap = 1'b0;
    pkt = {};
    for (int i = 0; i < 9; i++) pkt.push_back(8'h00);
    send(0, pkt, 1'b1);
    send(0, pkt, 1'b1);
    wait_idle();
    check("crc9_zero", crc9, 8'h00);

    // Abort a packet after 4 bytes with reset; no trailer may follow.
    pkt = {};
    for (int i = 0; i < 4; i++) pkt.push_back(8'h31 + 8'(i));
    send(0, pkt, 1'b0);
    wait_idle();
    #1 rst_ni = 1'b0;
    #2;
    check_reset();
    seq_m = '{default: 0};
    @(negedge clk_i);
    rst_ni = 1'b1;
    pkt = {};
    for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
    send(0, pkt, 1'b1);
    wait_idle();
    check("crc9_after_abort", crc9, 8'hF4);

    // Random packets on both instances.
    bp = 1'b1; gap = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pkt = {};
      for (int i = 0; i < 9; i++) pkt.push_back(8'($urandom_range(0, 255)));
      send(0, pkt, 1'b1);
      send(1, '{8'($urandom_range(0, 255))}, 1'b1);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
